bootrom_arbiter: RTL and testbench

- Shares the single-port, 1-cycle-latency boot ROM (512 x 32) between the CPU instruction-fetch port and the data-load port.
- The data port needs ROM access because the boot code copies initialised data out of ROM with word loads while fetching from ROM.
- Sits between the CPU bus split and the boot ROM.
- Performs grant arbitration, ROM address generation, response routing and write-fault flagging.

---
 rtl/bootrom_arbiter.sv | 159 +++++++++++++++
 tb/tb_bootrom_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter
//   Shares the single-port boot ROM (512 x 32, registered output, 1-cycle
//   latency) between the CPU instruction-fetch port (I) and the data-load
//   port (D). It arbitrates grants, drives the ROM word address, routes the
//   ROM data back to the port that was granted, and answers D-port writes
//   with a fault.
//
//   Ports
//     clk, reset_n          system clock, async active-low reset
//     i_req/i_addr          fetch request; i_ack grant, i_done/i_rddata response
//     d_req/d_wr/d_addr     data request; d_ack grant, d_done/d_rddata/d_err
//     rom_addr              ROM word address (combinational from the grant)
//     rom_rddata            ROM registered output
//
//   Build option
//     BOOTROM_ARB_RR_EN     defined: round-robin between I and D when both
//                           request. Undefined: D has priority, and I is
//                           granted after MAX_BURST consecutive D grants.
//
//   Owner tag (which response is due next cycle)
//     state     | meaning
//     OWN_NONE  | nothing granted last cycle, no done
//     OWN_I     | I read granted, i_done with ROM data
//     OWN_D     | D read granted, d_done with ROM data
//     OWN_DW    | D write granted, d_done with d_err and zero data

module bootrom_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_done,
    output logic [31:0] i_rddata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    output logic        d_ack,
    output logic        d_done,
    output logic [31:0] d_rddata,
    output logic        d_err,
    output logic [8:0]  rom_addr,
    input  logic [31:0] rom_rddata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_DW   = 2'd3
    } owner_e;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    owner_e     owner_q, owner_d;
    logic [3:0] burst_q, burst_d;
    logic       rr_q, rr_d;          // 1: pointer names D, 0: names I
    logic [8:0] rom_addr_q, rom_addr_d;
    logic       grant_i, grant_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= OWN_NONE;
            burst_q    <= '0;
            rr_q       <= 1'b1;
            rom_addr_q <= '0;
        end else begin
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            rr_q       <= rr_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        rr_d    = rr_q;
        burst_d = burst_q;

        // Acks are combinational, so they are gated by reset_n to keep every
        // output at 0 while reset is held.
        if (reset_n) begin
            if (i_req && d_req) begin
`ifdef BOOTROM_ARB_RR_EN
                if (rr_q) begin
                    grant_d = 1'b1;
                end else begin
                    grant_i = 1'b1;
                end
                rr_d = ~rr_q;
`else
                if (burst_q == BURST_LIMIT) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
`endif
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end

`ifdef BOOTROM_ARB_RR_EN
        burst_d = '0;
`else
        // Counts D grants made while I is kept waiting; any gap in i_req or
        // any I grant restarts the count.
        if (grant_d && i_req) begin
            burst_d = (burst_q == BURST_LIMIT) ? burst_q : burst_q + 4'd1;
        end else begin
            burst_d = '0;
        end
`endif

        owner_d = OWN_NONE;
        if (grant_i) begin
            owner_d = OWN_I;
        end else if (grant_d) begin
            owner_d = d_wr ? OWN_DW : OWN_D;
        end

        // The ROM is read every cycle; without a grant the address holds.
        rom_addr_d = rom_addr_q;
        if (grant_i) begin
            rom_addr_d = i_addr[10:2];
        end else if (grant_d) begin
            rom_addr_d = d_addr[10:2];
        end
    end

    assign i_ack    = grant_i;
    assign d_ack    = grant_d;
    assign rom_addr = rom_addr_d;

    assign i_done   = (owner_q == OWN_I);
    assign i_rddata = (owner_q == OWN_I) ? rom_rddata : 32'h0;
    assign d_done   = (owner_q == OWN_D) || (owner_q == OWN_DW);
    assign d_err    = (owner_q == OWN_DW);
    assign d_rddata = (owner_q == OWN_D) ? rom_rddata : 32'h0;

    // Accesses outside the ROM window alias into it and are answered
    // normally, so the window compare and the byte-offset bits feed nothing.
    logic unused_addr_bits;
    assign unused_addr_bits = (i_addr[31:11] == BASE_ADDR[31:11])
                            ^ (d_addr[31:11] == BASE_ADDR[31:11])
                            ^ (^i_addr[1:0]) ^ (^d_addr[1:0])
                            ^ (^BASE_ADDR[10:0]);

`ifdef BOOTROM_ARB_RR_EN
    logic unused_burst;
    assign unused_burst = (^burst_q) ^ (^BURST_LIMIT);
`endif

endmodule

// File: tb/tb_bootrom_arbiter.sv
module tb_bootrom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req, d_wr;
    logic [31:0] i_addr, d_addr;
    logic        i_ack, i_done, d_ack, d_done, d_err;
    logic [31:0] i_rddata, d_rddata, rom_rddata;
    logic [8:0]  rom_addr;

    always #5 clk = ~clk;

    bootrom_arbiter #(.BASE_ADDR(32'h0000_0000), .MAX_BURST(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_done(i_done), .i_rddata(i_rddata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_ack(d_ack), .d_done(d_done),
        .d_rddata(d_rddata), .d_err(d_err),
        .rom_addr(rom_addr), .rom_rddata(rom_rddata)
    );

    function automatic logic [31:0] rom_word(input logic [8:0] a);
        return {7'h55, a, 7'h2A, a};
    endfunction

    // Registered-output ROM model
    always @(posedge clk) rom_rddata <= rom_word(rom_addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // g: expected grant this cycle ("I", "D" or "-")
    // r: expected response this cycle ("I", "D", "W" write fault, "-"), rw = ROM word
    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_wr;
        logic [31:0] d_addr;
        byte         g;
        byte         r;
        logic [8:0]  rw;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da,
                                input byte g, input byte r, input logic [8:0] rw);
        vec_t v;
        v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_wr = dw; v.d_addr = da;
        v.g = g; v.r = r; v.rw = rw;
        vecs.push_back(v);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " i_ack"}, i_ack, 0);
        chk({tag, " d_ack"}, d_ack, 0);
        chk({tag, " i_done"}, i_done, 0);
        chk({tag, " d_done"}, d_done, 0);
        chk({tag, " d_err"}, d_err, 0);
        chk({tag, " i_rddata"}, i_rddata, 0);
        chk({tag, " d_rddata"}, d_rddata, 0);
        chk({tag, " rom_addr"}, rom_addr, 0);
    endtask

    localparam logic [31:0] IA = 32'h1000_0816;   // out of window, word 5, offset bits set
    localparam logic [31:0] DA = 32'h0000_0024;   // word 9

    initial begin
        vec_t       v;
        logic [8:0] exp_ra;

        // Common prefix: I stream, write fault, D read
        add(1, 32'h0, 0, 0, 32'h0,  "I", "-", 0);
        add(1, 32'h4, 0, 0, 32'h0,  "I", "I", 0);
        add(1, 32'h8, 0, 0, 32'h0,  "I", "I", 1);
        add(0, 32'h0, 0, 0, 32'h0,  "-", "I", 2);
        add(0, 32'h0, 1, 1, 32'h10, "D", "-", 0);
        add(0, 32'h0, 0, 0, 32'h0,  "-", "W", 0);
        add(0, 32'h0, 1, 0, 32'h20, "D", "-", 0);
`ifdef BOOTROM_ARB_RR_EN
        add(1, IA, 1, 0, DA, "D", "D", 8);
        add(1, IA, 1, 0, DA, "I", "D", 9);
        add(1, IA, 1, 0, DA, "D", "I", 5);
        add(1, IA, 1, 0, DA, "I", "D", 9);
        add(0, IA, 1, 0, DA, "D", "I", 5);
        add(1, IA, 1, 0, DA, "D", "D", 9);
        add(0, IA, 0, 0, DA, "-", "D", 9);
`else
        add(1, IA, 1, 0, DA, "D", "D", 8);
        for (int k = 0; k < 3; k++) add(1, IA, 1, 0, DA, "D", "D", 9);
        add(1, IA, 1, 0, DA, "I", "D", 9);
        add(1, IA, 1, 0, DA, "D", "I", 5);
        for (int k = 0; k < 3; k++) add(1, IA, 1, 0, DA, "D", "D", 9);
        add(1, IA, 1, 0, DA, "I", "D", 9);
        add(0, IA, 0, 0, DA, "-", "I", 5);
        add(1, IA, 1, 0, DA, "D", "-", 0);
        add(1, IA, 1, 0, DA, "D", "D", 9);
        add(1, IA, 1, 0, DA, "D", "D", 9);
        add(0, IA, 1, 0, DA, "D", "D", 9);   // i_req gap clears the burst count
        add(1, IA, 1, 0, DA, "D", "D", 9);   // one-cycle I request, never acked
        add(0, IA, 1, 0, DA, "D", "D", 9);
        for (int k = 0; k < 4; k++) add(1, IA, 1, 0, DA, "D", "D", 9);
        add(1, IA, 1, 0, DA, "I", "D", 9);
        add(0, IA, 0, 0, DA, "-", "I", 5);
`endif

        // Reset held with both requests high: everything stays 0
        reset_n = 1'b0;
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
        i_addr = 32'h44; d_addr = 32'h88;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        reset_n = 1'b1;

        exp_ra = 9'd0;
        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            @(negedge clk);
            i_req = v.i_req; i_addr = v.i_addr;
            d_req = v.d_req; d_wr = v.d_wr; d_addr = v.d_addr;
            #2;
            if (v.g == "I") exp_ra = v.i_addr[10:2];
            if (v.g == "D") exp_ra = v.d_addr[10:2];
            chk($sformatf("v%0d i_ack", k), i_ack, v.g == "I");
            chk($sformatf("v%0d d_ack", k), d_ack, v.g == "D");
            chk($sformatf("v%0d rom_addr", k), rom_addr, exp_ra);
            chk($sformatf("v%0d i_done", k), i_done, v.r == "I");
            chk($sformatf("v%0d d_done", k), d_done, (v.r == "D") || (v.r == "W"));
            chk($sformatf("v%0d d_err", k), d_err, v.r == "W");
            chk($sformatf("v%0d i_rddata", k), i_rddata, (v.r == "I") ? rom_word(v.rw) : 32'h0);
            chk($sformatf("v%0d d_rddata", k), d_rddata, (v.r == "D") ? rom_word(v.rw) : 32'h0);
        end

        // Grant to I, then reset mid-cycle before the response edge
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b0; d_wr = 1'b0;
        #2;
        chk("pre-reset i_ack", i_ack, 1);
        #1 reset_n = 1'b0;
        #1;
        chk_all_zero("mid-reset");
        @(negedge clk);
        i_req = 1'b0;
        reset_n = 1'b1;
        #2;
        chk("post-reset i_done", i_done, 0);
        chk("post-reset i_rddata", i_rddata, 0);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = DA;
        #2;
        chk("post-reset first grant d_ack", d_ack, 1);
        chk("post-reset first grant i_ack", i_ack, 0);
        chk("post-reset no stale i_done", i_done, 0);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        #2;
        chk("post-reset d_done", d_done, 1);
        chk("post-reset d_rddata", d_rddata, rom_word(9'd9));
        chk("post-reset i_done idle", i_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
